// File: rtl/sync_mul_unit_29_if.sv
// rtl/sync_mul_unit_29_if.sv - operand/result bundle for sync_mul_unit_29
//
// Purpose: groups the start/operand request and the result/status response
// of the sequential multiplier so the sequencer and the unit share one port.
//   iarg_A   M  multiplicand, two's complement
//   iarg_B   M  multiplier, two's complement
//   i_start  1  start request, sampled on the rising clock edge
//   o_busy   1  operation in progress
//   o_valid  1  one-cycle pulse when o_result/o_status update
//   o_result M  product (U2, or sign-magnitude with SYNC_MUL_29_ZM_OUT_EN)
//   o_status 4  {COL, N, Z, OV}
// master drives the request side, slave is the multiplier.
interface sync_mul_unit_29_if #(
  parameter int M = 32
);
  logic [M-1:0] iarg_A;
  logic [M-1:0] iarg_B;
  logic         i_start;
  logic         o_busy;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  modport master (
    output iarg_A, iarg_B, i_start,
    input  o_busy, o_valid, o_result, o_status
  );

  modport slave (
    input  iarg_A, iarg_B, i_start,
    output o_busy, o_valid, o_result, o_status
  );
endinterface

// File: rtl/sync_mul_unit_29.sv
// rtl/sync_mul_unit_29.sv - sequential signed shift-add multiplier, one partial product per clock
//
// Purpose: multiplies two M-bit two's-complement operands in M clocks using
// unsigned magnitudes and a 2M-bit accumulator, then applies the sign and
// reports overflow/zero/negative/collision status with a one-cycle valid pulse.
// Ports:
//   clk      in   system clock, rising edge
//   i_reset  in   asynchronous active-low reset
//   bus      slave side of sync_mul_unit_29_if (operands, start, busy,
//                 valid, result, status)
// Configuration macro: SYNC_MUL_29_ZM_OUT_EN
//   defined   : o_result is sign-magnitude, OV when |P| > 2^(M-1)-1
//   undefined : o_result is two's complement, wraps on overflow
module sync_mul_unit_29 #(
  parameter int M = 32
) (
  input  logic              clk,
  input  logic              i_reset,
  sync_mul_unit_29_if.slave bus
);
  localparam int CW = $clog2(M + 1);
  localparam int W2 = 2 * M;
  // Largest magnitude representable as a positive M-bit result.
  localparam logic [W2-1:0] LIM_POS = (W2'(1) << (M - 1)) - W2'(1);
`ifndef SYNC_MUL_29_ZM_OUT_EN
  // Largest magnitude representable as a negative M-bit U2 result.
  localparam logic [W2-1:0] LIM_NEG = W2'(1) << (M - 1);
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  logic [W2-1:0]   r_acc;
  logic [W2-1:0]   r_mcand;   // |A| shifted to the current bit position
  logic [M-1:0]    r_mplier;  // |B|, consumed LSB first
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_col;
  logic            r_busy;
  logic            r_valid;
  logic [M-1:0]    r_result;
  logic [3:0]      r_status;

  logic [M-1:0]    w_abs_a;
  logic [M-1:0]    w_abs_b;
  logic [W2-1:0]   w_acc_next;
  logic            w_neg;
  logic            w_ov;
  logic [M-1:0]    w_res;
  logic [3:0]      w_stat;

  // Magnitudes are M-bit unsigned, so -2^(M-1) maps cleanly to 2^(M-1).
  assign w_abs_a = bus.iarg_A[M-1] ? ((~bus.iarg_A) + M'(1)) : bus.iarg_A;
  assign w_abs_b = bus.iarg_B[M-1] ? ((~bus.iarg_B) + M'(1)) : bus.iarg_B;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // A zero product is always reported positive.
  assign w_neg = r_sign & (|w_acc_next);

`ifdef SYNC_MUL_29_ZM_OUT_EN
  assign w_ov  = (w_acc_next > LIM_POS);
  assign w_res = {w_neg, w_acc_next[M-2:0]};
`else
  assign w_ov  = w_neg ? (w_acc_next > LIM_NEG) : (w_acc_next > LIM_POS);
  // Low M bits of the negated product equal the negation of its low M bits,
  // which gives the wrapped result on overflow for free.
  assign w_res = w_neg ? ((~w_acc_next[M-1:0]) + M'(1)) : w_acc_next[M-1:0];
`endif

  // A start on the final RUN edge is still a collision for this operation.
  assign w_stat = {r_col | bus.i_start, w_res[M-1], ~(|w_res), w_ov};

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_col    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_status <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_sign   <= bus.iarg_A[M-1] ^ bus.iarg_B[M-1];
            r_mcand  <= {{M{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_cnt    <= CW'(M);
            r_col    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (bus.i_start) begin
            r_col <= 1'b1;
          end
          if (r_cnt == CW'(1)) begin
            r_result <= w_res;
            r_status <= w_stat;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;
  assign bus.o_status = r_status;
endmodule

// File: tb/tb_sync_mul_unit_29.sv
// tb/tb_sync_mul_unit_29.sv - self-checking bench for sync_mul_unit_29
module tb_sync_mul_unit_29;
  localparam int M = 32;

  logic clk = 1'b0;
  logic i_reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   t_valid = 0;

  sync_mul_unit_29_if #(.M(M)) bus ();

  sync_mul_unit_29 #(.M(M)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SYNC_MUL_29_ZM_OUT_EN
  localparam logic [31:0] E_NEG3X5_R  = 32'h8000000F;
  localparam logic [3:0]  E_MINX1_S   = 4'b0101;
  localparam logic [31:0] E_MINXM1_R  = 32'h00000000;
  localparam logic [3:0]  E_MINXM1_S  = 4'b0011;
`else
  localparam logic [31:0] E_NEG3X5_R  = 32'hFFFFFFF1;
  localparam logic [3:0]  E_MINX1_S   = 4'b0100;
  localparam logic [31:0] E_MINXM1_R  = 32'h80000000;
  localparam logic [3:0]  E_MINXM1_S  = 4'b0101;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product in 64-bit arithmetic, then the output format rules.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic col,
                       output logic [31:0] res, output logic [3:0] st);
    longint     p;
    longint     mag;
    logic [63:0] pv;
    logic       ov;
    p   = longint'($signed(a)) * longint'($signed(b));
    mag = (p < 0) ? -p : p;
`ifdef SYNC_MUL_29_ZM_OUT_EN
    ov  = (mag > longint'(2147483647));
    pv  = 64'(mag);
    res = (p == 0) ? 32'h0 : {(p < 0), pv[30:0]};
`else
    ov  = (p > longint'(2147483647)) || (p < (longint'(-2147483647) - 1));
    pv  = 64'(p);
    res = pv[31:0];
`endif
    st  = {col, res[31], (res == 32'h0), ov};
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.iarg_A  = a;
    bus.iarg_B  = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    t_start     = cyc;
    // Operands only need to hold at the acceptance edge.
    bus.iarg_A  = $urandom;
    bus.iarg_B  = $urandom;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int k = 0; k < M + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        got     = 1'b1;
        t_valid = cyc;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] es);
    bit got;
    start_op(a, b);
    wait_valid(got);
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(t_valid - t_start), 64'(M));
    check({tag, "_res"}, 64'(bus.o_result), 64'(er));
    check({tag, "_st"}, 64'(bus.o_status), 64'(es));
  endtask

  initial begin
    bit          got;
    int          nb;
    int          nv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mr;
    logic [3:0]  ms;
    logic [31:0] edge_vals [5];

    edge_vals[0] = 32'h80000000;
    edge_vals[1] = 32'h7FFFFFFF;
    edge_vals[2] = 32'hFFFFFFFF;
    edge_vals[3] = 32'h00000000;
    edge_vals[4] = 32'h00000001;

    i_reset     = 1'b0;
    bus.iarg_A  = '0;
    bus.iarg_B  = '0;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_res", 64'(bus.o_result), 64'd0);
    check("rst_st", 64'(bus.o_status), 64'd0);
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic op with busy-window measurement.
    start_op(32'd3, 32'd5);
    nb  = 0;
    got = 1'b0;
    for (int k = 0; k < M + 8; k++) begin
      if (bus.o_busy) nb++;
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        got     = 1'b1;
        t_valid = cyc;
        break;
      end
    end
    check("basic_valid", 64'(got), 64'd1);
    check("basic_lat", 64'(t_valid - t_start), 64'(M));
    check("basic_busy_cycles", 64'(nb), 64'(M));
    check("basic_busy_in_valid", 64'(bus.o_busy), 64'd0);
    check("basic_res", 64'(bus.o_result), 64'h0000000F);
    check("basic_st", 64'(bus.o_status), 64'b0000);
    @(posedge clk);
    #1;
    check("basic_valid_pulse", 64'(bus.o_valid), 64'd0);
    check("basic_res_hold", 64'(bus.o_result), 64'h0000000F);

    run_check("neg3x5", 32'hFFFFFFFD, 32'd5, E_NEG3X5_R, 4'b0100);
    run_check("minx1", 32'h80000000, 32'd1, 32'h80000000, E_MINX1_S);
    run_check("minxm1", 32'h80000000, 32'hFFFFFFFF, E_MINXM1_R, E_MINXM1_S);
    run_check("ovwrap", 32'h00010000, 32'h00010000, 32'h00000000, 4'b0011);
    run_check("zero", 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 4'b0010);

    // Collision: a start mid-RUN is flagged and neither restarts nor queues.
    start_op(32'd2, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    bus.iarg_A  = 32'd9;
    bus.iarg_B  = 32'd9;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_valid(got);
    check("col_valid", 64'(got), 64'd1);
    check("col_lat", 64'(t_valid - t_start), 64'(M));
    check("col_res", 64'(bus.o_result), 64'd6);
    check("col_st", 64'(bus.o_status), 64'b1000);

    // Back-to-back start in the valid cycle.
    start_op(32'h00007FFF, 32'd3);
    check("b2b_busy", 64'(bus.o_busy), 64'd1);
    wait_valid(got);
    check("b2b_valid", 64'(got), 64'd1);
    check("b2b_lat", 64'(t_valid - t_start), 64'(M));
    check("b2b_res", 64'(bus.o_result), 64'h00017FFD);
    check("b2b_st", 64'(bus.o_status), 64'b0000);

    // Reset mid-RUN abandons the operation.
    start_op(32'd7, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.o_busy), 64'd0);
    check("midrst_valid", 64'(bus.o_valid), 64'd0);
    check("midrst_res", 64'(bus.o_result), 64'd0);
    check("midrst_st", 64'(bus.o_status), 64'd0);
    @(negedge clk);
    i_reset = 1'b1;
    nv = 0;
    for (int k = 0; k < M + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) nv++;
    end
    check("midrst_no_valid", 64'(nv), 64'd0);
    run_check("after_rst", 32'd4, 32'd4, 32'd16, 4'b0000);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin
          a = $urandom;
          b = $urandom;
        end
        1: begin
          a = 32'($urandom_range(0, 200)) - 32'd100;
          b = 32'($urandom_range(0, 200)) - 32'd100;
        end
        default: begin
          a = edge_vals[$urandom_range(0, 4)];
          b = edge_vals[$urandom_range(0, 4)];
        end
      endcase
      model(a, b, 1'b0, mr, ms);
      run_check($sformatf("rnd%0d", i), a, b, mr, ms);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
